// File: rtl/jk_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_pkg
//  Description : Shared mode encodings for the JK counter bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

    // Operating mode selected per falling edge.
    typedef logic [1:0] jk_mode_t;

    localparam jk_mode_t JK_MODE_JK   = 2'b00;  // per-bit J/K update
    localparam jk_mode_t JK_MODE_UP   = 2'b01;  // count up modulo MODULUS
    localparam jk_mode_t JK_MODE_DOWN = 2'b10;  // count down modulo MODULUS
    localparam jk_mode_t JK_MODE_HOLD = 2'b11;  // hold value

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_counter_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : jk_counter_bank_if
//  Description : Control/data bundle between a controller and the JK counter
//                bank. Clock and preset stay outside as plain ports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jk_counter_bank_if
    import jk_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic             clear_i;  // synchronous clear, active-low
    logic             en_i;     // update enable, 0 = hold
    jk_mode_t         mode_i;   // operating mode
    logic [WIDTH-1:0] j_i;      // per-bit J (JK mode only)
    logic [WIDTH-1:0] k_i;      // per-bit K (JK mode only)
    logic [WIDTH-1:0] q_o;      // register value
    logic [WIDTH-1:0] qn_o;     // inverted register value
    logic             tc_o;     // registered wrap pulse

    // Controller side: drives the controls, observes the register.
    modport master (
        output clear_i, en_i, mode_i, j_i, k_i,
        input  q_o, qn_o, tc_o
    );

    // Counter bank side.
    modport slave (
        input  clear_i, en_i, mode_i, j_i, k_i,
        output q_o, qn_o, tc_o
    );

endinterface : jk_counter_bank_if
`default_nettype wire

// File: rtl/jk_counter_bank_cell.sv
`default_nettype none
// ============================================================================
//  Module      : jk_cell
//  Description : Single JK flip-flop, falling-edge clocked, asynchronous
//                active-low preset to a per-instance PRESET bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_cell #(
    parameter logic PRESET = 1'b0
) (
    input  wire logic clk_i,
    input  wire logic preset_i,
    input  wire logic j_i,
    input  wire logic k_i,
    output logic      q_o
);

    logic r_q;

    // JK update on the falling edge; preset wins asynchronously.
    always_ff @(negedge clk_i or negedge preset_i) begin
        if (!preset_i) begin
            r_q <= PRESET;
        end else begin
            case ({j_i, k_i})
                2'b01:   r_q <= 1'b0;   // reset
                2'b10:   r_q <= 1'b1;   // set
                2'b11:   r_q <= ~r_q;   // toggle
                default: r_q <= r_q;    // hold
            endcase
        end
    end

    assign q_o = r_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : jk_counter_bank
//  Description : WIDTH-bit bank of JK cells that can run a per-bit JK update,
//                count up/down modulo MODULUS, or hold. Every mode is turned
//                into a J/K vector for the cell array; a registered tc_o
//                pulse marks each wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_counter_bank
    import jk_pkg::*;
#(
    parameter int          WIDTH      = 8,
    // 33 bits so that MODULUS = 2**32 is representable for WIDTH = 32.
    parameter logic [32:0] MODULUS    = 33'd1 << WIDTH,
    parameter logic [32:0] PRESET_VAL = MODULUS - 33'd1
) (
    input  wire logic         clk_i,
    input  wire logic         preset_i,
    jk_counter_bank_if.slave  bus
);

    localparam logic [32:0]      c_MOD  = MODULUS;
    localparam logic [32:0]      c_LAST = MODULUS - 33'd1;
    localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MODULUS - 33'd1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] w_q;        // current register value from the cells
    logic [32:0]      w_q_ext;    // zero-extended for modulus comparisons
    logic [WIDTH-1:0] w_target;   // next value when not in raw JK mode
    logic             w_pass_jk;  // route j_i/k_i straight to the cells
    logic             w_tc_next;  // wrap detected this edge
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             r_tc;

    assign w_q_ext = 33'(w_q);

    // Next-value selection: clear, then enable, then mode.
    always_comb begin
        w_target  = w_q;
        w_pass_jk = 1'b0;
        w_tc_next = 1'b0;
        if (!bus.clear_i) begin
            w_target = c_ZERO;
        end else if (bus.en_i) begin
            case (bus.mode_i)
                JK_MODE_JK: begin
                    w_pass_jk = 1'b1;
                end
                JK_MODE_UP: begin
                    // Values at or above the last legal count wrap to zero.
                    if (w_q_ext >= c_LAST) begin
                        w_target  = c_ZERO;
                        w_tc_next = 1'b1;
                    end else begin
                        w_target = w_q + c_ONE;
                    end
                end
                JK_MODE_DOWN: begin
                    if (w_q == c_ZERO) begin
                        w_target  = c_MAX;
                        w_tc_next = 1'b1;
                    end else if (w_q_ext >= c_MOD) begin
                        // Out-of-range value left by JK mode: saturate
                        // back into range without signalling a wrap.
                        w_target = c_MAX;
                    end else begin
                        w_target = w_q - c_ONE;
                    end
                end
                default: begin
                    w_target = w_q;
                end
            endcase
        end
    end

    // A target value n is loaded into JK cells as J = n, K = ~n.
    assign w_j = w_pass_jk ? bus.j_i : w_target;
    assign w_k = w_pass_jk ? bus.k_i : ~w_target;

    // One JK cell per bit, each presetting to its bit of PRESET_VAL.
    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_cell
            jk_cell #(
                .PRESET (PRESET_VAL[g])
            ) u_cell (
                .clk_i    (clk_i),
                .preset_i (preset_i),
                .j_i      (w_j[g]),
                .k_i      (w_k[g]),
                .q_o      (w_q[g])
            );
        end
    endgenerate

    // Wrap pulse register; preset drops any pending pulse.
    always_ff @(negedge clk_i or negedge preset_i) begin
        if (!preset_i) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_tc_next;
        end
    end

    assign bus.q_o  = w_q;
    assign bus.qn_o = ~w_q;
    assign bus.tc_o = r_tc;

endmodule : jk_counter_bank
`default_nettype wire

// File: tb/tb_jk_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_counter_bank
//  Description : Self-checking bench for jk_counter_bank. DUT A: WIDTH=4,
//                MODULUS=10, PRESET_VAL=9. DUT B: WIDTH=3, MODULUS=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_counter_bank;
    import jk_pkg::*;

    logic clk = 1'b0;
    logic preset_a;
    logic preset_b;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: plain integers, updated from the behavioural rules.
    longint qa  = 9;
    bit     tca = 1'b0;
    longint qb  = 7;
    bit     tcb = 1'b0;

    jk_counter_bank_if #(.WIDTH(4)) ifa ();
    jk_counter_bank_if #(.WIDTH(3)) ifb ();

    jk_counter_bank #(
        .WIDTH      (4),
        .MODULUS    (33'd10),
        .PRESET_VAL (33'd9)
    ) dut_a (
        .clk_i    (clk),
        .preset_i (preset_a),
        .bus      (ifa.slave)
    );

    jk_counter_bank #(
        .WIDTH      (3),
        .MODULUS    (33'd8)
    ) dut_b (
        .clk_i    (clk),
        .preset_i (preset_b),
        .bus      (ifb.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, required end");
        $fatal(1);
    end

    // Behavioural model of one falling edge with preset released.
    function automatic void model_step(input int w, input longint m,
                                       input bit clr, input bit en,
                                       input logic [1:0] mode,
                                       input logic [31:0] j, input logic [31:0] k,
                                       inout longint q, inout bit tc);
        longint mask;
        mask = (longint'(1) << w) - 1;
        tc = 1'b0;
        if (!clr) begin
            q = 0;
        end else if (!en || mode == 2'b11) begin
            q = q;
        end else if (mode == 2'b00) begin
            for (int b = 0; b < w; b++) begin
                if (j[b] && k[b])      q = q ^ (longint'(1) << b);
                else if (j[b])         q = q | (longint'(1) << b);
                else if (k[b])         q = q & ~(longint'(1) << b);
            end
        end else if (mode == 2'b01) begin
            if (q >= m - 1) begin q = 0; tc = 1'b1; end
            else            q = q + 1;
        end else begin
            if (q == 0)       begin q = m - 1; tc = 1'b1; end
            else if (q >= m)  q = m - 1;
            else              q = q - 1;
        end
        q = q & mask;
    endfunction

    task automatic set_a(input bit clr, input bit en, input logic [1:0] mode,
                         input logic [3:0] j, input logic [3:0] k);
        ifa.clear_i = clr; ifa.en_i = en; ifa.mode_i = mode;
        ifa.j_i = j; ifa.k_i = k;
    endtask

    task automatic set_b(input bit clr, input bit en, input logic [1:0] mode,
                         input logic [2:0] j, input logic [2:0] k);
        ifb.clear_i = clr; ifb.en_i = en; ifb.mode_i = mode;
        ifb.j_i = j; ifb.k_i = k;
    endtask

    // Advance the models with the currently driven inputs, then one edge.
    task automatic tick();
        if (preset_a)
            model_step(4, 10, ifa.clear_i, ifa.en_i, ifa.mode_i,
                       32'(ifa.j_i), 32'(ifa.k_i), qa, tca);
        if (preset_b)
            model_step(3, 8, ifb.clear_i, ifb.en_i, ifb.mode_i,
                       32'(ifb.j_i), 32'(ifb.k_i), qb, tcb);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (ifa.q_o !== 4'd9 || ifa.qn_o !== 4'h6 || ifa.tc_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_a: got q=%h qn=%h tc=%b, required q=9 qn=6 tc=0",
                         ifa.q_o, ifa.qn_o, ifa.tc_o);
            end
            vectors++;
            if (ifb.q_o !== 3'd7 || ifb.tc_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_b: got q=%h tc=%b, required q=7 tc=0", ifb.q_o, ifb.tc_o);
            end
        end
    endtask

    task automatic test_preset_release();
        preset_a = 1'b1;
        set_a(1, 1, JK_MODE_UP, 4'h0, 4'h0);
        tick();
        vectors++;
        if (ifa.q_o !== 4'd0 || ifa.tc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL release_wrap: got q=%h tc=%b, required q=0 tc=1", ifa.q_o, ifa.tc_o);
        end
        tick();
        vectors++;
        if (ifa.q_o !== 4'd1 || ifa.tc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL release_count: got q=%h tc=%b, required q=1 tc=0", ifa.q_o, ifa.tc_o);
        end
    endtask

    task automatic test_down_wrap();
        set_a(0, 1, JK_MODE_UP, 4'h0, 4'h0);
        tick();
        set_a(1, 1, JK_MODE_DOWN, 4'h0, 4'h0);
        tick();
        vectors++;
        if (ifa.q_o !== 4'd9 || ifa.tc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL down_wrap: got q=%h tc=%b, required q=9 tc=1", ifa.q_o, ifa.tc_o);
        end
        set_a(1, 1, JK_MODE_JK, 4'hC, 4'h3);
        tick();
        vectors++;
        if (ifa.q_o !== 4'hC || ifa.tc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL jk_load_c: got q=%h tc=%b, required q=c tc=0", ifa.q_o, ifa.tc_o);
        end
        set_a(1, 1, JK_MODE_DOWN, 4'h0, 4'h0);
        tick();
        vectors++;
        if (ifa.q_o !== 4'd9 || ifa.tc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL down_out_of_range: got q=%h tc=%b, required q=9 tc=0", ifa.q_o, ifa.tc_o);
        end
    endtask

    task automatic test_jk_bitwise();
        set_a(1, 1, JK_MODE_JK, 4'b1010, 4'b0101);
        tick();
        // Per bit (msb first): hold 1, set 1, toggle 1->0, reset 0 => 1100.
        set_a(1, 1, JK_MODE_JK, 4'b0110, 4'b0011);
        tick();
        vectors++;
        if (ifa.q_o !== 4'b1100 || ifa.q_o !== qa[3:0]) begin
            miscompares++;
            $display("FAIL jk_bitwise: got q=%b, required q=%b", ifa.q_o, 4'b1100);
        end
    endtask

    task automatic test_priority();
        logic [3:0] held;
        set_a(1, 1, JK_MODE_JK, 4'h9, 4'h6);
        tick();
        set_a(0, 1, JK_MODE_UP, 4'h0, 4'h0);
        tick();
        vectors++;
        if (ifa.q_o !== 4'd0 || ifa.tc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_priority: got q=%h tc=%b, required q=0 tc=0", ifa.q_o, ifa.tc_o);
        end
        // Produce a tc pulse, then disable: the pulse must not persist.
        set_a(1, 1, JK_MODE_JK, 4'h9, 4'h6);
        tick();
        set_a(1, 1, JK_MODE_UP, 4'h0, 4'h0);
        tick();
        held = ifa.q_o;
        for (int m = 0; m < 4; m++) begin
            set_a(1, 0, 2'(m), 4'($urandom), 4'($urandom));
            tick();
            vectors++;
            if (ifa.q_o !== 4'd0 || ifa.tc_o !== 1'b0) begin
                miscompares++;
                $display("FAIL enable_hold mode=%0d: got q=%h tc=%b, required q=0 tc=0",
                         m, ifa.q_o, ifa.tc_o);
            end
        end
        set_a(1, 1, JK_MODE_HOLD, 4'hF, 4'hF);
        tick();
        vectors++;
        if (ifa.q_o !== held || ifa.tc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_hold: got q=%h tc=%b, required q=%h tc=0", ifa.q_o, ifa.tc_o, held);
        end
    endtask

    task automatic test_full_modulus();
        int pulses;
        pulses = 0;
        preset_b = 1'b1;
        set_b(1, 1, JK_MODE_UP, 3'h0, 3'h0);
        set_a(1, 0, JK_MODE_HOLD, 4'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (ifb.tc_o === 1'b1) pulses++;
            vectors++;
            if (ifb.q_o !== 3'(i % 8) || ifb.tc_o !== (i % 8 == 0)) begin
                miscompares++;
                $display("FAIL full_mod edge %0d: got q=%0d tc=%b, required q=%0d tc=%b",
                         i, ifb.q_o, ifb.tc_o, i % 8, (i % 8 == 0));
            end
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL full_mod_pulses: got %0d, required 2", pulses);
        end
        set_b(1, 0, JK_MODE_HOLD, 3'h0, 3'h0);
    endtask

    task automatic test_mid_preset();
        set_a(0, 1, JK_MODE_UP, 4'h0, 4'h0);
        tick();
        set_a(1, 1, JK_MODE_UP, 4'h0, 4'h0);
        repeat (5) tick();
        vectors++;
        if (ifa.q_o !== 4'd5) begin
            miscompares++;
            $display("FAIL mid_preset_setup: got q=%h, required q=5", ifa.q_o);
        end
        #2 preset_a = 1'b0; qa = 9; tca = 1'b0;
        #1;
        vectors++;
        if (ifa.q_o !== 4'd9 || ifa.qn_o !== 4'h6 || ifa.tc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_preset: got q=%h qn=%h tc=%b, required q=9 qn=6 tc=0",
                     ifa.q_o, ifa.qn_o, ifa.tc_o);
        end
        tick();
        preset_a = 1'b1;
        tick();
        vectors++;
        if (ifa.q_o !== 4'd0 || ifa.tc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL preset_release_wrap: got q=%h tc=%b, required q=0 tc=1", ifa.q_o, ifa.tc_o);
        end
        // Pending pulse is dropped by a preset between edges.
        #2 preset_a = 1'b0; qa = 9; tca = 1'b0;
        #1;
        vectors++;
        if (ifa.tc_o !== 1'b0 || ifa.q_o !== 4'd9) begin
            miscompares++;
            $display("FAIL preset_drops_tc: got q=%h tc=%b, required q=9 tc=0", ifa.q_o, ifa.tc_o);
        end
        preset_a = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(31) == 0) begin
                preset_a = 1'b0; qa = 9; tca = 1'b0;
                #1 preset_a = 1'b1;
            end
            set_a($urandom_range(15) != 0, $urandom_range(7) != 0, 2'($urandom),
                  4'($urandom), 4'($urandom));
            set_b($urandom_range(15) != 0, $urandom_range(7) != 0, 2'($urandom),
                  3'($urandom), 3'($urandom));
            tick();
            vectors++;
            if (ifa.q_o !== qa[3:0] || ifa.qn_o !== ~qa[3:0] || ifa.tc_o !== tca) begin
                miscompares++;
                $display("FAIL random_a %0d: got q=%h qn=%h tc=%b, required q=%h qn=%h tc=%b",
                         i, ifa.q_o, ifa.qn_o, ifa.tc_o, qa[3:0], ~qa[3:0], tca);
            end
            vectors++;
            if (ifb.q_o !== qb[2:0] || ifb.tc_o !== tcb) begin
                miscompares++;
                $display("FAIL random_b %0d: got q=%h tc=%b, required q=%h tc=%b",
                         i, ifb.q_o, ifb.tc_o, qb[2:0], tcb);
            end
        end
    endtask

    initial begin
        preset_a = 1'b0;
        preset_b = 1'b0;
        set_a(1, 1, JK_MODE_UP, 4'h0, 4'h0);
        set_b(1, 0, JK_MODE_HOLD, 3'h0, 3'h0);
        test_reset();
        test_preset_release();
        test_down_wrap();
        test_jk_bitwise();
        test_priority();
        test_full_modulus();
        test_mid_preset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_jk_counter_bank
`default_nettype wire
